mips_multicycle_controller: RTL
===============================

Name: mips_multicycle_controller

Overview:
- Multicycle MIPS control unit and parametrised successor to the single-cycle ALU decoder.
- Sequences each instruction through a Moore FSM (fetch, decode, execute, memory, writeback).
- Produces datapath selects and write enables plus ALUControl.
- Supports configurable memory latency. Adds ori with zero-extension, per-instruction done pulse and illegal-opcode flag.

Parameters:
- MEM_LAT, 1, cycles per memory access (FETCH, MEMRD, MEMWR); legal range 1..15.
- CNT_W, 4, width of the internal wait counter; must hold MEM_LAT-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- zero  in  1  ALU zero flag
- IorD  out  1  0 = PC addresses memory, 1 = ALUOut
- MemWrite  out  1  memory write enable
- IRWrite  out  1  instruction register load
- RegDst  out  1  1 = rd, 0 = rt
- MemtoReg  out  1  1 = Data register, 0 = ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ExtZero  out  1  1 = zero-extend imm, 0 = sign-extend
- PCSrc  out  2  00 ALUResult, 01 ALUOut, 10 jump target
- PCEn  out  1  PC load = PCWrite | (Branch & zero)
- ALUControl  out  3  000 and, 001 or, 010 add, 110 sub, 111 slt
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode

Behaviour:
- Reset:
  - rst sampled on clk; state <= FETCH, wait_cnt <= 0.
  - While rst=1, MemWrite, IRWrite, RegWrite, PCEn, instr_done and illegal_op are forced 0.
  - All other outputs take their FETCH values.
  - rst mid-instruction abandons it; no write occurs in the rst cycle.
- Outputs: combinational from state only (Moore), except PCEn, which also uses zero. Unlisted outputs are 0. ALUOp is internal.
- ALUOp to ALUControl:
  - 00 gives add; 01 gives sub; 11 gives or.
  - 10 decodes funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt; any other funct gives add.
- Wait counter:
  - In FETCH, MEMRD and MEMWR, wait_cnt increments each cycle.
  - The state exits when wait_cnt == MEM_LAT-1, and wait_cnt clears on exit.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the last wait cycle.
  - Then go to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - Next state by op: 100011/101011 to MEMADR; 000000 to EXECUTE; 000100 to BRANCH; 001000 to ADDIEXEC; 001101 to ORIEXEC; 000010 to JUMP.
  - Any other op: illegal_op=1, instr_done=1, next state FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. op 100011 goes to MEMRD; otherwise MEMWR.
- MEMRD: IorD=1 for MEM_LAT cycles, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, then FETCH.
- MEMWR: IorD=1 and MemWrite=1 for all MEM_LAT cycles. instr_done=1 in the last cycle, then FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10, then ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1, then FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00, then IMMWB.
- ORIEXEC: ALUSrcA=1, ALUSrcB=10, ExtZero=1, ALUOp=11, then IMMWB.
- IMMWB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, then FETCH.
- JUMP: PCSrc=10, PCWrite=1, instr_done=1, then FETCH.
- Latency with L=MEM_LAT:
  - lw 2L+3 cycles; sw 2L+2.
  - R-type, addi and ori L+3.
  - beq, j L+2.
  - illegal L+1.
- Unreachable state encodings return to FETCH on the next clock, with all enables 0.

Optional Feature:
- Macro: MIPS_EXT_ALU_EN.
- Defined: ALUOp=10 additionally decodes funct 100110 (xor) to ALUControl 011 and 100111 (nor) to 101.
- Undefined: 100110 and 100111 fall to the default, add (010).

Test Plan:
- rst=1 held 3 cycles, then released, MEM_LAT=1: during reset all write enables are 0. The first cycle after reset is FETCH with IRWrite=1, PCEn=1, ALUSrcB=01.
- lw, op=100011, MEM_LAT=3: 9 cycles; IorD=1 for exactly 3 MEMRD cycles; RegWrite and MemtoReg both 1 with instr_done=1 in cycle 9.
- sw, op=101011, MEM_LAT=3: MemWrite high for exactly 3 consecutive cycles; 8 cycles total; RegWrite never asserted.
- beq with zero=1, then zero=0: PCEn=1 in BRANCH for zero=1 and 0 for zero=0; ALUControl=110 in both runs.
- R-type with funct 100000, 100010, 100100, 100101, 101010, 100111: ALUControl in EXECUTE is 010, 110, 000, 001, 111. The last funct gives 010, or 101 with MIPS_EXT_ALU_EN defined.
- op=111111, then rst pulsed during MEMRD of a following lw: illegal_op and instr_done pulse for 1 cycle in DECODE. The rst cycle shows RegWrite=0, and the machine restarts at FETCH.

Source files
------------

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/memory/writeback.
// Optional macro MIPS_EXT_ALU_EN adds xor/nor funct decoding for R-type instructions.
module mips_multicycle_controller #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic [2:0] ALUControl,
  output logic       instr_done,
  output logic       illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ORIEXEC  = 4'd10,
    S_IMMWB    = 4'd11,
    S_JUMP     = 4'd12
  } state_t;

  function automatic logic [2:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    logic [2:0] ctl;
    ctl = 3'b010;
    case (aluop)
      2'b00: ctl = 3'b010;
      2'b01: ctl = 3'b110;
      2'b11: ctl = 3'b001;
      default: begin
        case (fn)
          6'b100000: ctl = 3'b010;
          6'b100010: ctl = 3'b110;
          6'b100100: ctl = 3'b000;
          6'b100101: ctl = 3'b001;
          6'b101010: ctl = 3'b111;
`ifdef MIPS_EXT_ALU_EN
          6'b100110: ctl = 3'b011;
          6'b100111: ctl = 3'b101;
`endif
          default:   ctl = 3'b010;
        endcase
      end
    endcase
    return ctl;
  endfunction

  function automatic logic op_is_legal(input logic [5:0] opc);
    return (opc == OP_LW) || (opc == OP_SW) || (opc == OP_RTYPE) || (opc == OP_BEQ) ||
           (opc == OP_ADDI) || (opc == OP_ORI) || (opc == OP_J);
  endfunction

  state_t           state, next_state, out_state;
  logic [CNT_W-1:0] wait_cnt, cnt_next;
  logic             wait_last, wait_state;
  logic [1:0]       aluop;
  logic             pcwrite, branch;

  assign wait_last  = (wait_cnt == CNT_LAST);
  assign wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= cnt_next;
    end
  end

  // Memory-facing states hold for MEM_LAT cycles; the counter is idle (zero) elsewhere.
  always_comb begin
    cnt_next = '0;
    if (wait_state && !wait_last) cnt_next = wait_cnt + CNT_W'(1);
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = wait_last ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = S_EXECUTE;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXEC;
          OP_ORI:       next_state = S_ORIEXEC;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    next_state = wait_last ? S_MEMWB : S_MEMRD;
      S_MEMWR:    next_state = wait_last ? S_FETCH : S_MEMWR;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEXEC: next_state = S_IMMWB;
      S_ORIEXEC:  next_state = S_IMMWB;
      default:    next_state = S_FETCH;
    endcase
  end

  // While rst is high the outputs look like FETCH, with every enable suppressed.
  always_comb begin
    out_state  = rst ? S_FETCH : state;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ExtZero    = 1'b0;
    PCSrc      = 2'b00;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    aluop      = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (out_state)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        if (wait_last) begin
          IRWrite = 1'b1;
          pcwrite = 1'b1;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (!op_is_legal(op)) begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD:  IorD = 1'b1;
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        MemWrite   = 1'b1;
        instr_done = wait_last;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        aluop      = 2'b01;
        PCSrc      = 2'b01;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ORIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtZero = 1'b1;
        aluop   = 2'b11;
      end
      S_IMMWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    ALUControl = alu_decode(aluop, funct);
    PCEn       = pcwrite | (branch & zero);
    if (rst) begin
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      PCEn       = 1'b0;
      instr_done = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule
